// File: rtl/buttons_event_queue_pkg.sv
// buttons_pkg: shared definitions for the button event queue.
//   - event type encoding (PRESS/RELEASE/LONG/REPEAT)
//   - EVT_W / ID_W widths and the number of buttons
//   - evt_t: packed {type, id} event word as it sits in the FIFO
package buttons_pkg;

   localparam int EVT_W   = 4;
   localparam int ID_W    = 2;
   localparam int NUM_BTN = 4;

   typedef enum logic [1:0] {
      EVT_PRESS   = 2'd0,
      EVT_RELEASE = 2'd1,
      EVT_LONG    = 2'd2,
      EVT_REPEAT  = 2'd3
   } evt_type_e;

   typedef struct packed {
      evt_type_e         etype;
      logic [ID_W-1:0]   id;
   } evt_t;

endpackage

// File: rtl/buttons_event_queue_if.sv
// buttons_event_queue_if: valid/ready event stream from the queue to the
// peripheral bridge.
//   evt_valid  head holds an event
//   evt_data   head event {type, id}
//   evt_ready  consumer accepts the head
// master = event source (queue), slave = consumer (bridge).
interface buttons_event_queue_if;
   import buttons_pkg::*;

   logic evt_valid;
   evt_t evt_data;
   logic evt_ready;

   modport master (output evt_valid, output evt_data, input evt_ready);
   modport slave  (input evt_valid, input evt_data, output evt_ready);

endinterface

// File: rtl/buttons_event_queue_tracker.sv
// button_event_tracker: per-button event generator.
//   clk, rst_n  clock / async active-low reset
//   btn         debounced level, 1 = pressed
//   clr         arbiter grant: the pending slot is consumed this cycle
//   pending     one-entry slot holds an event
//   ptype       type of the pending event
//   drop        a new event arrived while the slot was still occupied
module button_event_tracker
   import buttons_pkg::*;
#(
   parameter int LONG_TICKS   = 50_000_000,
   parameter int REPEAT_TICKS = 10_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn,
   input  logic       clr,
   output logic       pending,
   output logic [1:0] ptype,
   output logic       drop
);

   localparam int MAX_T = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
   localparam int CNT_W = $clog2(MAX_T) + 1;

   logic             prev;
   logic             long_done, done_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             new_evt;
   evt_type_e        new_type;

   // Edges take precedence over thresholds, so a release sampled on the
   // LONG/REPEAT threshold edge yields RELEASE only.
   always_comb begin
      new_evt  = 1'b0;
      new_type = EVT_PRESS;
      cnt_nxt  = cnt;
      done_nxt = long_done;
      if (btn && !prev) begin
         new_evt  = 1'b1;
         new_type = EVT_PRESS;
         cnt_nxt  = '0;
         done_nxt = 1'b0;
      end else if (!btn && prev) begin
         new_evt  = 1'b1;
         new_type = EVT_RELEASE;
         cnt_nxt  = '0;
         done_nxt = 1'b0;
      end else if (btn && prev) begin
         if (!long_done) begin
            if (cnt == CNT_W'(LONG_TICKS - 1)) begin
               new_evt  = 1'b1;
               new_type = EVT_LONG;
               cnt_nxt  = '0;
               done_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end else if (REPEAT_TICKS != 0) begin
            if (cnt == CNT_W'(REPEAT_TICKS - 1)) begin
               new_evt  = 1'b1;
               new_type = EVT_REPEAT;
               cnt_nxt  = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         // REPEAT disabled: counter parks after LONG
      end
   end

   // A slot being granted this cycle is free for a new event.
   assign drop = new_evt && pending && !clr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev      <= 1'b0;
         cnt       <= '0;
         long_done <= 1'b0;
         pending   <= 1'b0;
         ptype     <= 2'd0;
      end else begin
         prev      <= btn;
         cnt       <= cnt_nxt;
         long_done <= done_nxt;
         if (new_evt && !drop) begin
            pending <= 1'b1;
            ptype   <= new_type;
         end else if (clr) begin
            pending <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/buttons_event_queue.sv
// buttons_event_queue: turns four debounced button levels into PRESS /
// RELEASE / LONG / REPEAT events, queued in a FIFO and drained over a
// valid/ready port.
//   clk, rst_n     clock / async active-low reset
//   btn_0..btn_3   debounced levels, 1 = pressed
//   evt            event stream (master): evt_valid, evt_data, evt_ready
//   evt_count      FIFO occupancy 0..FIFO_DEPTH
//   overflow       sticky: an event was lost
//   overflow_clr   synchronous clear of overflow (a same-cycle set wins)
module buttons_event_queue
   import buttons_pkg::*;
#(
   parameter int LONG_TICKS   = 50_000_000,
   parameter int REPEAT_TICKS = 10_000_000,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        btn_0,
   input  logic                        btn_1,
   input  logic                        btn_2,
   input  logic                        btn_3,
   buttons_event_queue_if.master       evt,
   output logic [$clog2(FIFO_DEPTH):0] evt_count,
   output logic                        overflow,
   input  logic                        overflow_clr
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   logic [NUM_BTN-1:0]      btn, pend, grant, drop;
   logic [NUM_BTN-1:0][1:0] ptype;

   logic          can_write, wr_en, pop;
   evt_t          wr_evt;
   evt_t          mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;

   assign btn = {btn_3, btn_2, btn_1, btn_0};

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_trk
      button_event_tracker #(
         .LONG_TICKS   (LONG_TICKS),
         .REPEAT_TICKS (REPEAT_TICKS)
      ) u_trk (
         .clk     (clk),
         .rst_n   (rst_n),
         .btn     (btn[g]),
         .clr     (grant[g]),
         .pending (pend[g]),
         .ptype   (ptype[g]),
         .drop    (drop[g])
      );
   end

   assign pop       = evt.evt_valid && evt.evt_ready;
   // a pop frees the head slot in time for a same-cycle write
   assign can_write = (count < CW'(FIFO_DEPTH)) || pop;

   // Fixed priority: lowest-index pending button wins.
   always_comb begin
      grant  = '0;
      wr_en  = 1'b0;
      wr_evt = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
         if (pend[i] && can_write && !wr_en) begin
            grant[i]     = 1'b1;
            wr_en        = 1'b1;
            wr_evt.etype = evt_type_e'(ptype[i]);
            wr_evt.id    = ID_W'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= wr_evt;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            overflow <= 1'b0;
      else if (|drop)        overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
   end

   // Head is read straight from registered storage; forced to zero when empty.
   assign evt.evt_valid = (count != '0);
   assign evt.evt_data  = evt.evt_valid ? mem[rd_ptr] : '0;
   assign evt_count     = count;

endmodule

// File: doc/buttons_event_queue.md
# buttons_event_queue

Consumes the four debounced, active-high button levels produced by the buttons controller and turns them into a stream of discrete events: PRESS, RELEASE, LONG and auto-REPEAT. Events are buffered in a small FIFO and drained by the CPU-side peripheral bridge through a valid/ready port. Per-button trackers feed a fixed-priority arbiter that writes at most one event per cycle.

## Interface
- LONG_TICKS, 50_000_000 — cycles a button must be held after PRESS before LONG is emitted; ≥2.
- REPEAT_TICKS, 10_000_000 — cycles between REPEAT events after LONG; 0 disables REPEAT.
- FIFO_DEPTH, 8 — event FIFO entries; power of two, ≥2.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- btn_0, btn_1, btn_2, btn_3  in  1 each  debounced button levels, 1 = pressed; already synchronous to clk.
- evt_valid  out  1  FIFO head holds an event.
- evt_data  out  4  head event: [3:2] type, [1:0] button id.
- evt_ready  in  1  consumer accepts the head when evt_valid is high.
- evt_count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky; an event was lost.
- overflow_clr  in  1  synchronous clear of overflow.

## Operation
- Event types: PRESS=0, RELEASE=1, LONG=2, REPEAT=3.
- Per button: `prev` register, hold counter, `long_done` flag, one-entry pending slot holding the type.
- Rising level (btn=1, prev=0): PRESS pending; counter cleared; long_done cleared.
- Falling level: RELEASE pending; counter and long_done cleared.
- While held: counter increments each cycle. At LONG_TICKS cycles after the PRESS edge, LONG is pending, long_done is set and the counter is cleared. After that, each REPEAT_TICKS cycles emits REPEAT, unless REPEAT_TICKS=0.
- Release sampled on the same edge as the LONG/REPEAT threshold: RELEASE only.
- Arbiter: each cycle grants the lowest-index button with a pending slot, provided the FIFO can accept a write. A grant clears that slot and writes {type,id}.
- FIFO can accept a write when count<FIFO_DEPTH, or when a pop happens in the same cycle.
- Pending slot still full when a new event arises: the new event is dropped and overflow is set. Blocked pending events wait; they are never dropped.
- Pop: evt_valid && evt_ready. Push and pop in the same cycle leave the count unchanged.
- Pointers wrap modulo FIFO_DEPTH. Count range is 0..FIFO_DEPTH.
- overflow: a set condition and overflow_clr in the same cycle leave it set (set wins).

## Timing
- Reset (asynchronous, rst_n=0): evt_valid=0, evt_data=0, evt_count=0, overflow=0. prev, counters, long_done, pending slots and pointers are all cleared.
- A button held through reset release therefore yields a PRESS after reset.
- Latency, with an idle FIFO and no contention:
  - Level change sampled at edge E0 sets the pending slot at E0.
  - Write happens at E1.
  - evt_valid is high from E1 until the pop edge.
- evt_data is the registered FIFO head. It is stable while evt_valid=1 and evt_ready=0.
- Back-to-back pops are supported at one per cycle.
- With 4 simultaneous presses, events arrive in id order 0,1,2,3 on consecutive write cycles.

## Structure
- Package buttons_pkg holds:
  - event type constants;
  - EVT_W=4 and ID_W=2;
  - an event struct/typedef {type, id}.
- Sub-module button_event_tracker: one instance per button, generated in a loop. It contains the edge detect, hold counter, long_done and pending slot, and exposes pending/type/clear/drop ports.
- FIFO and arbiter live in the top module.

## Test plan
Parameters: LONG_TICKS=8, REPEAT_TICKS=4, FIFO_DEPTH=4.
- Short press:
  - Stimulus: btn_2 high for 3 cycles then low, with evt_ready=1.
  - Response: evt_data 4'b0010 (PRESS, id 2), then 4'b0110 (RELEASE, id 2); no LONG; overflow=0.
- Long hold with repeat:
  - Stimulus: btn_0 held for 20 cycles.
  - Response: PRESS at E1; LONG (4'b1000) written 8 cycles after the press edge; REPEAT (4'b1100) at +12 and +16; RELEASE after.
- Simultaneous press:
  - Stimulus: all buttons rise on one edge, with evt_ready=0.
  - Response: FIFO holds 0x0,0x1,0x2,0x3; evt_count=4.
- FIFO full and overflow:
  - Stimulus: FIFO full with evt_ready=0; btn_0 toggles twice.
  - Response: the first event waits in its slot; the second is dropped and overflow=1.
  - Follow-up: raising evt_ready drains the 4 queued events plus the waiting one.
- Simultaneous push/pop at full:
  - Stimulus: count=4, pop and grant in the same cycle.
  - Response: count stays 4; the new event is appended.
- Reset mid-hold:
  - Stimulus: btn_1 held and rst_n pulsed low with 3 events queued.
  - Response: all outputs are 0 during reset; after release a single PRESS id 1 appears; overflow=0.
